uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Byte-level command decoder that consumes the synchronised receive byte stream (data bus plus single-cycle valid pulse) produced by the UART receive-path bus synchroniser in the system clock domain. It parses multi-byte command frames and issues register-file write/read strobes and ALU-enable strobes to the system datapath. Malformed frames are flagged, and stalled frames are aborted by a timeout.

## Interface
Parameters:
- DATA_WIDTH, 8, width of received byte and register write data
- ADDR_WIDTH, 4, register-file address width
- TIMEOUT_CYCLES, 1024, consecutive idle CLK cycles tolerated mid-frame before abort (≥2)

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- RX_P_DATA  in  DATA_WIDTH  synchronised received byte; valid only when RX_D_VLD=1
- RX_D_VLD  in  1  single-cycle byte-valid pulse
- RF_WrEn  out  1  register write strobe, 1 cycle
- RF_RdEn  out  1  register read strobe, 1 cycle
- RF_Address  out  ADDR_WIDTH  register address, held between strobes
- RF_WrData  out  DATA_WIDTH  register write data, held between strobes
- ALU_EN  out  1  ALU start strobe, 1 cycle
- ALU_FUN  out  4  ALU function code, held between strobes
- CMD_DONE  out  1  frame completed, 1 cycle
- CMD_ERR  out  1  unknown command byte, 1 cycle
- FRAME_ERR  out  1  frame aborted by timeout, 1 cycle

## Operation
- A byte is accepted on every CLK edge with RX_D_VLD=1. Back-to-back valid cycles are legal.
- Command bytes are decoded in IDLE:
  - 0xAA: register write; frame is CMD, ADDR, DATA.
  - 0xBB: register read; frame is CMD, ADDR.
  - 0xCC: ALU with operands; frame is CMD, OPA, OPB, FUN.
  - 0xDD: ALU without operands; frame is CMD, FUN.
  - Any other byte: CMD_ERR pulse; stay in IDLE.
- States and transitions, each taken on an accepted byte:
  - IDLE→WR_ADDR (0xAA), IDLE→RD_ADDR (0xBB), IDLE→ALU_A (0xCC), IDLE→ALU_F (0xDD).
  - WR_ADDR: latch RF_Address=byte[ADDR_WIDTH-1:0]; go to WR_DATA.
  - WR_DATA: RF_WrData=byte, RF_WrEn pulse, CMD_DONE pulse; go to IDLE.
  - RD_ADDR: RF_Address=byte[ADDR_WIDTH-1:0], RF_RdEn pulse, CMD_DONE pulse; go to IDLE.
  - ALU_A: RF_Address=0, RF_WrData=byte, RF_WrEn pulse; go to ALU_B.
  - ALU_B: RF_Address=1, RF_WrData=byte, RF_WrEn pulse; go to ALU_F.
  - ALU_F: ALU_FUN=byte[3:0], ALU_EN pulse, CMD_DONE pulse; go to IDLE.
- Address and function bytes are truncated. Upper bits are ignored and no error is raised.
- Timeout:
  - An idle counter clears on every accepted byte and in IDLE.
  - It increments on each non-IDLE cycle without RX_D_VLD.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to IDLE and FRAME_ERR pulses. No strobe is issued for the partial frame.
  - Already-issued operand writes are not undone.
- Simultaneous events: RX_D_VLD in the same cycle the counter would expire means the byte is accepted and the counter clears; no abort occurs.
- Bytes arriving in IDLE are always interpreted as commands. This includes trailing bytes after an abort.

## Timing
- Reset (RST=1 at a CLK edge): state IDLE, counter 0, and all outputs 0.
  - Covers RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CMD_DONE, CMD_ERR and FRAME_ERR.
  - Reset mid-frame discards the frame silently. No error pulse.
- All outputs are registered. The strobe/pulse for a byte accepted at edge N is high for exactly the cycle after edge N.
- RF_Address/RF_WrData/ALU_FUN update at the same edge their strobe asserts, and hold afterwards.
- CMD_DONE is coincident with the final strobe of the frame. CMD_ERR and FRAME_ERR are coincident with no other strobe.
- A new command byte may arrive the cycle immediately after a frame's final byte; it is decoded with no lost cycle.
- Abort timing: with the last byte at edge N and no further valid, FRAME_ERR is high in the cycle after edge N+TIMEOUT_CYCLES.

## Test plan
- **Register write.** Reset, then bytes 0xAA, 0x05, 0x3C on consecutive valid cycles. Required: one cycle with RF_WrEn=1, RF_Address=5 and RF_WrData=0x3C, with CMD_DONE=1 in that same cycle. RF_RdEn and ALU_EN stay 0.
- **Register read and ALU without operands.** Bytes 0xBB, 0x0A, then 0xDD, 0x02. Required: an RF_RdEn pulse with RF_Address=0xA, then an ALU_EN pulse with ALU_FUN=2. Each strobe comes with one CMD_DONE pulse.
- **ALU with operands.** Bytes 0xCC, 0x11, 0x22, 0x03, spaced 5 cycles apart. Required, in order:
  - RF_WrEn with addr 0, data 0x11;
  - RF_WrEn with addr 1, data 0x22;
  - ALU_EN with ALU_FUN=3 and CMD_DONE.
- **Unknown command.** Byte 0x55 in IDLE gives one CMD_ERR pulse and no other strobe. A following 0xAA, 0x01, 0xFF completes normally.
- **Timeout.** With TIMEOUT_CYCLES=8, send 0xAA, 0x03, then nothing. Required: FRAME_ERR in the cycle after the 8th idle edge, with no RF_WrEn. In a second run, a valid byte arriving exactly at the expiry edge is accepted and no FRAME_ERR occurs.
- **Reset mid-frame.** Send 0xCC, 0x44, then RST=1 for one cycle, then 0xDD, 0x07. Required: all outputs are 0 after reset and no error pulse occurs. The next frame produces ALU_EN with ALU_FUN=7.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
//
// Parses the synchronised UART receive byte stream into command frames and
// issues register-file write/read strobes and ALU start strobes.
//
// Frames (first byte decoded in IDLE):
//   0xAA ADDR DATA        register write
//   0xBB ADDR             register read
//   0xCC OPA OPB FUN      ALU with operands (operands written to RF[0], RF[1])
//   0xDD FUN              ALU without operands
//
// A stalled frame is aborted after TIMEOUT_CYCLES consecutive cycles without
// a valid byte. Unknown command bytes raise CMD_ERR.
//
// Ports:
//   CLK, RST            system clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD  received byte and its single-cycle valid pulse
//   RF_WrEn/RF_RdEn     register-file write/read strobes (1 cycle)
//   RF_Address          register address, held between strobes
//   RF_WrData           register write data, held between strobes
//   ALU_EN/ALU_FUN      ALU start strobe and held function code
//   CMD_DONE            frame completed, coincident with final strobe
//   CMD_ERR             unknown command byte
//   FRAME_ERR           frame aborted by timeout
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a command byte
// WR_ADDR | write frame, waiting for address byte
// WR_DATA | write frame, waiting for data byte (issues write)
// RD_ADDR | read frame, waiting for address byte (issues read)
// ALU_A   | ALU frame, waiting for operand A (written to RF[0])
// ALU_B   | ALU frame, waiting for operand B (written to RF[1])
// ALU_F   | ALU frame, waiting for function byte (starts ALU)
// -----------------------------------------------------------------------------
module uart_cmd_decoder #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [ADDR_WIDTH-1:0] RF_Address,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   output logic                  ALU_EN,
   output logic [3:0]            ALU_FUN,
   output logic                  CMD_DONE,
   output logic                  CMD_ERR,
   output logic                  FRAME_ERR
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      ALU_A   = 3'd4,
      ALU_B   = 3'd5,
      ALU_F   = 3'd6
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

   // Idle timer is a down-counter: loaded with TIMEOUT_CYCLES-1 whenever a
   // byte arrives or the FSM is in IDLE, and the frame aborts on a dry cycle
   // with the timer already at zero (i.e. the TIMEOUT_CYCLES-th idle edge).
   localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t                  state, state_nxt;
   logic [TMR_W-1:0]        tmr, tmr_nxt;
   logic [ADDR_WIDTH-1:0]   addr_hold, addr_hold_nxt;

   logic                    wr_en_nxt, rd_en_nxt, alu_en_nxt;
   logic                    done_nxt, cmd_err_nxt, frame_err_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [DATA_WIDTH-1:0]   wr_data_nxt;
   logic [3:0]              fun_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         tmr        <= TMR_LOAD;
         addr_hold  <= '0;
         RF_WrEn    <= 1'b0;
         RF_RdEn    <= 1'b0;
         RF_Address <= '0;
         RF_WrData  <= '0;
         ALU_EN     <= 1'b0;
         ALU_FUN    <= 4'd0;
         CMD_DONE   <= 1'b0;
         CMD_ERR    <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         state      <= state_nxt;
         tmr        <= tmr_nxt;
         addr_hold  <= addr_hold_nxt;
         RF_WrEn    <= wr_en_nxt;
         RF_RdEn    <= rd_en_nxt;
         RF_Address <= addr_nxt;
         RF_WrData  <= wr_data_nxt;
         ALU_EN     <= alu_en_nxt;
         ALU_FUN    <= fun_nxt;
         CMD_DONE   <= done_nxt;
         CMD_ERR    <= cmd_err_nxt;
         FRAME_ERR  <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      tmr_nxt       = tmr;
      addr_hold_nxt = addr_hold;
      wr_en_nxt     = 1'b0;
      rd_en_nxt     = 1'b0;
      alu_en_nxt    = 1'b0;
      done_nxt      = 1'b0;
      cmd_err_nxt   = 1'b0;
      frame_err_nxt = 1'b0;
      addr_nxt      = RF_Address;
      wr_data_nxt   = RF_WrData;
      fun_nxt       = ALU_FUN;

      if (RX_D_VLD) begin
         // A byte always wins over an expiring timer.
         tmr_nxt = TMR_LOAD;
         case (state)
            IDLE: begin
               case (RX_P_DATA)
                  CMD_WR:     state_nxt = WR_ADDR;
                  CMD_RD:     state_nxt = RD_ADDR;
                  CMD_ALU_OP: state_nxt = ALU_A;
                  CMD_ALU:    state_nxt = ALU_F;
                  default:    cmd_err_nxt = 1'b1;
               endcase
            end
            WR_ADDR: begin
               // Address is held internally so RF_Address only moves with a strobe.
               addr_hold_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
               state_nxt     = WR_DATA;
            end
            WR_DATA: begin
               addr_nxt    = addr_hold;
               wr_data_nxt = RX_P_DATA;
               wr_en_nxt   = 1'b1;
               done_nxt    = 1'b1;
               state_nxt   = IDLE;
            end
            RD_ADDR: begin
               addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
               rd_en_nxt = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
            ALU_A: begin
               addr_nxt    = '0;
               wr_data_nxt = RX_P_DATA;
               wr_en_nxt   = 1'b1;
               state_nxt   = ALU_B;
            end
            ALU_B: begin
               addr_nxt    = ADDR_WIDTH'(1);
               wr_data_nxt = RX_P_DATA;
               wr_en_nxt   = 1'b1;
               state_nxt   = ALU_F;
            end
            ALU_F: begin
               fun_nxt    = RX_P_DATA[3:0];
               alu_en_nxt = 1'b1;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state != IDLE) begin
         if (tmr == '0) begin
            frame_err_nxt = 1'b1;
            tmr_nxt       = TMR_LOAD;
            state_nxt     = IDLE;
         end else begin
            tmr_nxt = tmr - 1'b1;
         end
      end else begin
         tmr_nxt = TMR_LOAD;
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

   localparam int T_OUT = 8;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic       RF_WrEn, RF_RdEn, ALU_EN, CMD_DONE, CMD_ERR, FRAME_ERR;
   logic [3:0] RF_Address;
   logic [7:0] RF_WrData;
   logic [3:0] ALU_FUN;

   uart_cmd_decoder #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(T_OUT)
   ) dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
      .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
      .CMD_DONE(CMD_DONE), .CMD_ERR(CMD_ERR), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   // strobes = {wr, rd, alu, done, cerr, ferr}
   typedef struct packed {
      logic [5:0]  strobes;
      logic        chk_data;
      logic [3:0]  addr;
      logic [7:0]  wdata;
      logic [3:0]  fun;
      logic [31:0] cyc;
   } evt_t;

   typedef struct packed {
      logic [7:0]  b;
      logic [7:0]  gap;
      logic        has;
      evt_t        e;
   } vec_t;

   evt_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_cnt = 0;

   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   function automatic evt_t mk_evt(input logic [5:0] s, input logic [3:0] a,
                                   input logic [7:0] d, input logic [3:0] f);
      evt_t e;
      e.strobes  = s;
      e.chk_data = s[5] | s[4] | s[3];
      e.addr     = a;
      e.wdata    = d;
      e.fun      = f;
      e.cyc      = '0;
      return e;
   endfunction

   function automatic vec_t mk_vec(input logic [7:0] b, input int gap, input logic has,
                                   input logic [5:0] s, input logic [3:0] a,
                                   input logic [7:0] d, input logic [3:0] f);
      vec_t v;
      v.b   = b;
      v.gap = 8'(gap);
      v.has = has;
      v.e   = mk_evt(s, a, d, f);
      return v;
   endfunction

   // Scoreboard: every output pulse must match the oldest expected event.
   always begin
      @(posedge CLK);
      #1;
      if (RF_WrEn | RF_RdEn | ALU_EN | CMD_DONE | CMD_ERR | FRAME_ERR) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe cyc=%0d got wr/rd/alu/done/cerr/ferr=%b required none",
                     edge_cnt, {RF_WrEn, RF_RdEn, ALU_EN, CMD_DONE, CMD_ERR, FRAME_ERR});
         end else begin
            evt_t e;
            logic ok;
            e  = sb.pop_front();
            ok = ({RF_WrEn, RF_RdEn, ALU_EN, CMD_DONE, CMD_ERR, FRAME_ERR} == e.strobes)
                 && (edge_cnt == int'(e.cyc));
            if (e.chk_data)
               ok = ok && (RF_Address == e.addr) && (RF_WrData == e.wdata) && (ALU_FUN == e.fun);
            if (!ok) begin
               n_fail++;
               $display("FAIL event cyc=%0d got strobes=%b addr=%h wdata=%h fun=%h ; required cyc=%0d strobes=%b addr=%h wdata=%h fun=%h",
                        edge_cnt, {RF_WrEn, RF_RdEn, ALU_EN, CMD_DONE, CMD_ERR, FRAME_ERR},
                        RF_Address, RF_WrData, ALU_FUN, e.cyc, e.strobes, e.addr, e.wdata, e.fun);
            end
         end
      end
   end

   task automatic drive(input logic [7:0] b, input int gap, input logic has,
                        input evt_t e, input int off);
      evt_t x;
      for (int i = 0; i < gap; i++) begin
         @(negedge CLK);
         RX_D_VLD = 1'b0;
      end
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      if (has) begin
         x     = e;
         x.cyc = 32'(edge_cnt + 1 + off);
         sb.push_back(x);
      end
   endtask

   task automatic idle(input int n);
      @(negedge CLK);
      RX_D_VLD = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   task automatic drain_check(input string name);
      idle(3);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d expected events never seen, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic check_reset_state(input string name);
      n_checks++;
      if ({RF_WrEn, RF_RdEn, ALU_EN, CMD_DONE, CMD_ERR, FRAME_ERR, RF_Address, RF_WrData, ALU_FUN} != '0) begin
         n_fail++;
         $display("FAIL %s: got strobes=%b addr=%h wdata=%h fun=%h required all 0", name,
                  {RF_WrEn, RF_RdEn, ALU_EN, CMD_DONE, CMD_ERR, FRAME_ERR},
                  RF_Address, RF_WrData, ALU_FUN);
      end
   endtask

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_WR   = 6'b100000;
   localparam logic [5:0] S_WRD  = 6'b100100;
   localparam logic [5:0] S_RDD  = 6'b010100;
   localparam logic [5:0] S_ALUD = 6'b001100;
   localparam logic [5:0] S_CERR = 6'b000010;
   localparam logic [5:0] S_FERR = 6'b000001;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[19];
      evt_t none_e;
      none_e = mk_evt(S_NONE, 4'h0, 8'h00, 4'h0);

      vecs[0]  = mk_vec(8'hAA, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[1]  = mk_vec(8'h05, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[2]  = mk_vec(8'h3C, 0, 1, S_WRD,  4'h5, 8'h3C, 4'h0);
      vecs[3]  = mk_vec(8'hBB, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[4]  = mk_vec(8'h0A, 0, 1, S_RDD,  4'hA, 8'h3C, 4'h0);
      vecs[5]  = mk_vec(8'hDD, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[6]  = mk_vec(8'h02, 0, 1, S_ALUD, 4'hA, 8'h3C, 4'h2);
      vecs[7]  = mk_vec(8'hCC, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[8]  = mk_vec(8'h11, 4, 1, S_WR,   4'h0, 8'h11, 4'h2);
      vecs[9]  = mk_vec(8'h22, 4, 1, S_WR,   4'h1, 8'h22, 4'h2);
      vecs[10] = mk_vec(8'h03, 4, 1, S_ALUD, 4'h1, 8'h22, 4'h3);
      vecs[11] = mk_vec(8'h55, 0, 1, S_CERR, 4'h0, 8'h00, 4'h0);
      vecs[12] = mk_vec(8'hAA, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[13] = mk_vec(8'h01, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[14] = mk_vec(8'hFF, 0, 1, S_WRD,  4'h1, 8'hFF, 4'h3);
      vecs[15] = mk_vec(8'hBB, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[16] = mk_vec(8'hF7, 0, 1, S_RDD,  4'h7, 8'hFF, 4'h3);
      vecs[17] = mk_vec(8'hDD, 0, 0, S_NONE, 4'h0, 8'h00, 4'h0);
      vecs[18] = mk_vec(8'h3E, 0, 1, S_ALUD, 4'h7, 8'hFF, 4'hE);

      RST = 1'b1;
      RX_D_VLD = 1'b0;
      RX_P_DATA = 8'h00;
      repeat (3) @(negedge CLK);
      check_reset_state("reset_state");
      RST = 1'b0;

      // Table: write, read, ALU, spaced ALU, unknown command, truncation.
      for (int i = 0; i < 19; i++)
         drive(vecs[i].b, int'(vecs[i].gap), vecs[i].has, vecs[i].e, 0);
      drain_check("table_pending");

      // Timeout: FRAME_ERR after the T_OUT-th idle edge, then a trailing byte
      // is decoded as a command.
      drive(8'hAA, 0, 0, none_e, 0);
      drive(8'h03, 0, 1, mk_evt(S_FERR, 4'h0, 8'h00, 4'h0), T_OUT);
      idle(T_OUT + 4);
      drive(8'h03, 0, 1, mk_evt(S_CERR, 4'h0, 8'h00, 4'h0), 0);
      drain_check("timeout_pending");

      // Byte arriving exactly on the expiry edge is accepted, no abort.
      drive(8'hAA, 0, 0, none_e, 0);
      drive(8'h03, T_OUT - 1, 0, none_e, 0);
      drive(8'h77, T_OUT - 1, 1, mk_evt(S_WRD, 4'h3, 8'h77, 4'hE), 0);
      drain_check("expiry_edge_pending");

      // Reset mid-frame: operand write already issued, then silent discard.
      drive(8'hCC, 0, 0, none_e, 0);
      drive(8'h44, 0, 1, mk_evt(S_WR, 4'h0, 8'h44, 4'hE), 0);
      @(negedge CLK);
      RX_D_VLD = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check_reset_state("mid_frame_reset_state");
      drive(8'hDD, 0, 0, none_e, 0);
      drive(8'h07, 0, 1, mk_evt(S_ALUD, 4'h0, 8'h00, 4'h7), 0);
      drain_check("post_reset_pending");
      idle(T_OUT + 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
